multi_digit_display_ctrl: RTL and testbench

MULTI_DIGIT_DISPLAY_CTRL -- requirements
Module: multi_digit_display_ctrl

---
 rtl/display_pkg.sv | 69 ++++++
 rtl/bin2bcd_seq.sv | 51 +++++
 rtl/multi_digit_display_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_multi_digit_display_ctrl.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/display_pkg.sv
// Shared types, segment glyphs and helpers for the multi-digit display controller.
package display_pkg;

  // Conversion sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } conv_state_t;

  // Display radix selected by the mode button.
  typedef enum logic {
    MODE_HEX = 1'b0,
    MODE_DEC = 1'b1
  } disp_mode_t;

  // Active-low glyphs, bit 0 = segment A ... bit 6 = segment G.
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_A     = 7'h08;
  localparam logic [6:0] SEG_B     = 7'h03;
  localparam logic [6:0] SEG_C     = 7'h46;
  localparam logic [6:0] SEG_D     = 7'h21;
  localparam logic [6:0] SEG_E     = 7'h06;
  localparam logic [6:0] SEG_F     = 7'h0E;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Nibble to active-low glyph.
  function automatic logic [6:0] seg_glyph(input logic [3:0] nib);
    logic [6:0] g;
    case (nib)
      4'h0:    g = SEG_0;
      4'h1:    g = SEG_1;
      4'h2:    g = SEG_2;
      4'h3:    g = SEG_3;
      4'h4:    g = SEG_4;
      4'h5:    g = SEG_5;
      4'h6:    g = SEG_6;
      4'h7:    g = SEG_7;
      4'h8:    g = SEG_8;
      4'h9:    g = SEG_9;
      4'hA:    g = SEG_A;
      4'hB:    g = SEG_B;
      4'hC:    g = SEG_C;
      4'hD:    g = SEG_D;
      4'hE:    g = SEG_E;
      default: g = SEG_F;
    endcase
    return g;
  endfunction

  // Largest decimal number that fits on n digits (10^n - 1).
  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift/add-3 iteration per clock.
// done is high during the final iteration cycle; bcd is valid from the next cycle
// until the next start. Digits above NUM_DIGITS are discarded, so bcd holds
// bin mod 10^NUM_DIGITS.
module bin2bcd_seq #(
  parameter int DATA_W     = 16,
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [DATA_W-1:0]       bin,
  output logic [4*NUM_DIGITS-1:0] bcd,
  output logic                    done
);

  localparam int BCD_W = 4 * NUM_DIGITS;
  localparam int CNT_W = $clog2(DATA_W + 1);

  logic [DATA_W-1:0] shreg;
  logic [CNT_W-1:0]  iter_cnt;
  logic [BCD_W-1:0]  bcd_adj;

  // Add-3 correction on every BCD digit that is 5 or more before the shift.
  always_comb begin
    bcd_adj = bcd;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (bcd[4*d +: 4] >= 4'd5) bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
    end
  end

  // Load on start, then shift binary MSB into BCD LSB while the iteration down-counter runs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      shreg    <= '0;
      bcd      <= '0;
      iter_cnt <= '0;
    end else if (start) begin
      shreg    <= bin;
      bcd      <= '0;
      iter_cnt <= CNT_W'(DATA_W);
    end else if (iter_cnt != '0) begin
      bcd      <= {bcd_adj[BCD_W-2:0], shreg[DATA_W-1]};
      shreg    <= shreg << 1;
      iter_cnt <= iter_cnt - CNT_W'(1);
    end
  end

  assign done = (iter_cnt == CNT_W'(1));

endmodule

// File: rtl/multi_digit_display_ctrl.sv
// Multiplexed seven-segment display controller with hex/decimal mode,
// leading-zero blanking and overflow dashes.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | capture value and mode, start the converter
// ST_SHIFT | converter running DATA_W double-dabble iterations
// ST_DONE  | latch digits/blanking/overflow into the display register
module multi_digit_display_ctrl
  import display_pkg::*;
#(
  parameter int NUM_DIGITS  = 4,
  parameter int DATA_W      = 16,
  parameter int REFRESH_DIV = 100000,
  parameter int LZ_BLANK    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_W-1:0]     value,
  input  logic                  mode_btn,
  output logic [6:0]            seg,
  output logic                  dp,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  overflow,
  output logic                  busy
);

  localparam int HEX_BITS = 4 * NUM_DIGITS;
  localparam int WIDE_W   = (DATA_W > HEX_BITS) ? DATA_W : HEX_BITS;
  localparam int IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int REF_W    = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [63:0] DEC_MAX = pow10_m1(NUM_DIGITS);

  logic                  btn_s1, btn_s2, btn_q;
  disp_mode_t            mode;
  conv_state_t           state;
  logic [DATA_W-1:0]     cap_value;
  disp_mode_t            cap_mode;
  logic                  conv_start, conv_done;
  logic [HEX_BITS-1:0]   conv_bcd;
  logic [WIDE_W-1:0]     wide_val;
  logic [HEX_BITS-1:0]   dig_n;
  logic [NUM_DIGITS-1:0] blank_n;
  logic                  lz_seen;
  logic                  ovf_n;
  logic [HEX_BITS-1:0]   disp_nib;
  logic [NUM_DIGITS-1:0] disp_blank;
  disp_mode_t            disp_mode;
  logic                  disp_valid;
  logic [REF_W-1:0]      refresh_cnt;
  logic [IDX_W-1:0]      scan_idx;
  logic                  scan_live;
  logic [3:0]            cur_nib;
  logic [6:0]            cur_seg;

  // Two-flop synchroniser plus a history flop for rising-edge detection.
  always_ff @(posedge clk) begin
    if (!reset) begin
      btn_s1 <= 1'b0;
      btn_s2 <= 1'b0;
      btn_q  <= 1'b0;
    end else begin
      btn_s1 <= mode_btn;
      btn_s2 <= btn_s1;
      btn_q  <= btn_s2;
    end
  end

  // Toggle the display radix once per synchronised press.
  always_ff @(posedge clk) begin
    if (!reset) begin
      mode <= MODE_HEX;
    end else if (btn_s2 && !btn_q) begin
      mode <= (mode == MODE_HEX) ? MODE_DEC : MODE_HEX;
    end
  end

  assign conv_start = (state == ST_IDLE);

  bin2bcd_seq #(
    .DATA_W     (DATA_W),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_bin2bcd (
    .clk   (clk),
    .reset (reset),
    .start (conv_start),
    .bin   (value),
    .bcd   (conv_bcd),
    .done  (conv_done)
  );

  // Digits, overflow and leading-zero mask for the captured value, consumed in ST_DONE.
  always_comb begin
    wide_val = WIDE_W'(cap_value);
    dig_n    = (cap_mode == MODE_DEC) ? conv_bcd : wide_val[HEX_BITS-1:0];
    ovf_n    = (cap_mode == MODE_DEC) ? (64'(cap_value) > DEC_MAX)
                                      : ((wide_val >> HEX_BITS) != '0);
    blank_n  = '0;
    lz_seen  = 1'b0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      if (dig_n[4*i +: 4] != 4'd0) lz_seen = 1'b1;
      blank_n[i] = (LZ_BLANK != 0) && !lz_seen && (i != 0);
    end
  end

  // Conversion sequencer; the display register only ever changes in ST_DONE.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      busy       <= 1'b0;
      cap_value  <= '0;
      cap_mode   <= MODE_HEX;
      disp_nib   <= '0;
      disp_blank <= '0;
      disp_mode  <= MODE_HEX;
      disp_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          cap_value <= value;
          cap_mode  <= mode;
          state     <= ST_SHIFT;
          busy      <= 1'b1;
        end
        ST_SHIFT: begin
          if (conv_done) state <= ST_DONE;
        end
        ST_DONE: begin
          disp_nib   <= dig_n;
          disp_blank <= blank_n;
          disp_mode  <= cap_mode;
          disp_valid <= 1'b1;
          overflow   <= ovf_n;
          state      <= ST_IDLE;
          busy       <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  // Refresh divider; each wrap moves the scan to the next digit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
      scan_live   <= 1'b0;
    end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      scan_idx    <= (scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : scan_idx + IDX_W'(1);
      scan_live   <= 1'b1;
    end else begin
      refresh_cnt <= refresh_cnt + REF_W'(1);
    end
  end

  // Glyph for the digit currently scanned; blank until the first conversion lands.
  always_comb begin
    cur_nib = disp_nib[int'(scan_idx)*4 +: 4];
    if (!disp_valid)                 cur_seg = SEG_BLANK;
    else if (overflow)               cur_seg = SEG_DASH;
    else if (disp_blank[scan_idx])   cur_seg = SEG_BLANK;
    else                             cur_seg = seg_glyph(cur_nib);
  end

  // Registered pad drivers so an, seg and dp always switch together.
  always_ff @(posedge clk) begin
    if (!reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= scan_live ? ~(NUM_DIGITS'(1) << scan_idx) : '1;
      seg <= cur_seg;
      dp  <= !((disp_mode == MODE_DEC) && (scan_idx == '0));
    end
  end

endmodule

// File: tb/tb_multi_digit_display_ctrl.sv
// Directed plus randomized bench for multi_digit_display_ctrl (REFRESH_DIV=4).
module tb_multi_digit_display_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [15:0] value = 16'h0000;
  logic        mode_btn = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        overflow;
  logic        busy;

  int checks = 0;
  int errors = 0;
  bit exp_dec = 1'b0;

  // Lit segments per glyph, letters a..g.
  string glyph_lit [16] = '{"abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg", "abc",
                            "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg", "adefg", "aefg"};

  multi_digit_display_ctrl #(
    .NUM_DIGITS  (4),
    .DATA_W      (16),
    .REFRESH_DIV (4),
    .LZ_BLANK    (1)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .value    (value),
    .mode_btn (mode_btn),
    .seg      (seg),
    .dp       (dp),
    .an       (an),
    .overflow (overflow),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running expected=finished");
    $fatal(1);
  end

  function automatic logic [6:0] lit_to_seg(string s);
    logic [6:0] r;
    r = 7'h7F;
    for (int i = 0; i < s.len(); i++) r[int'(s[i]) - 97] = 1'b0;
    return r;
  endfunction

  // Expected glyph on digit k for value v, computed from place values.
  function automatic logic [6:0] model_seg(int v, bit dec, int k);
    int base;
    int p;
    base = dec ? 10 : 16;
    p = 1;
    for (int i = 0; i < k; i++) p = p * base;
    if (dec && v > 9999) return lit_to_seg("g");
    if (k > 0 && v < p) return 7'h7F;
    return lit_to_seg(glyph_lit[(v / p) % base]);
  endfunction

  task automatic check1(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(string tag);
    check1({tag, ":an"}, 32'(an), 32'hF);
    check1({tag, ":seg"}, 32'(seg), 32'h7F);
    check1({tag, ":dp"}, 32'(dp), 32'h1);
    check1({tag, ":overflow"}, 32'(overflow), 32'h0);
    check1({tag, ":busy"}, 32'(busy), 32'h0);
  endtask

  // Called right after reset release at a negedge: the next posedge is the first capture.
  task automatic first_conversion(string tag);
    int  lat;
    bit  early;
    lat = 0;
    early = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (seg !== 7'h7F) early = 1'b1;
      if (!busy) begin
        lat = c;
        break;
      end
    end
    check1({tag, ":latency"}, 32'(lat), 32'd18);
    check1({tag, ":blank_before_done"}, 32'(early), 32'd0);
  endtask

  task automatic check_display(string tag);
    bit seen [4];
    int nseen;
    int v;
    bit bad_an;
    nseen = 0;
    bad_an = 1'b0;
    for (int k = 0; k < 4; k++) seen[k] = 1'b0;
    repeat (40) @(negedge clk);
    v = int'(value);
    check1({tag, ":overflow"}, 32'(overflow), 32'(exp_dec && v > 9999));
    for (int c = 0; c < 40 && nseen < 4; c++) begin
      @(negedge clk);
      if ($countones(~an) != 1) bad_an = 1'b1;
      else begin
        for (int k = 0; k < 4; k++) begin
          if (!an[k] && !seen[k]) begin
            seen[k] = 1'b1;
            nseen++;
            check1($sformatf("%s:seg%0d", tag, k), 32'(seg), 32'(model_seg(v, exp_dec, k)));
            check1($sformatf("%s:dp%0d", tag, k), 32'(dp), 32'(!(exp_dec && k == 0)));
          end
        end
      end
    end
    check1({tag, ":all_digits_scanned"}, 32'(nseen), 32'd4);
    check1({tag, ":an_onehot"}, 32'(bad_an), 32'd0);
  endtask

  task automatic press_mode(int hold);
    mode_btn = 1'b1;
    repeat (hold) @(negedge clk);
    mode_btn = 1'b0;
    repeat (4) @(negedge clk);
    exp_dec = !exp_dec;
  endtask

  initial begin
    int sel;
    bit got_busy;

    // Reset and first conversion in HEX.
    value = 16'h270F;
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check_reset("reset");
    reset = 1'b1;
    first_conversion("first_conv");
    check_display("hex_270f");

    // DEC mode, full-scale and leading-zero blanking.
    press_mode(2);
    check_display("dec_9999");
    value = 16'h0001;
    check_display("dec_0001");
    value = 16'h0000;
    check_display("dec_0000");

    // Decimal overflow, then back to HEX.
    value = 16'h2710;
    check_display("dec_ovf");
    press_mode(2);
    check_display("hex_2710");

    // Long press toggles exactly once.
    value = 16'h00AB;
    press_mode(20);
    check_display("long_press");

    // Randomized values with occasional mode presses.
    for (int n = 0; n < 14; n++) begin
      if ($urandom_range(0, 2) == 0) press_mode(2);
      sel = int'($urandom_range(0, 3));
      case (sel)
        0:       value = 16'($urandom);
        1:       value = 16'($urandom_range(0, 9999));
        2:       value = 16'($urandom_range(0, 255));
        default: value = 16'($urandom_range(9990, 10010));
      endcase
      check_display($sformatf("rand%0d", n));
    end

    // Reset mid-conversion.
    value = 16'h1234;
    got_busy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      if (busy) begin
        got_busy = 1'b1;
        break;
      end
    end
    check1("busy_seen", 32'(got_busy), 32'd1);
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_reset("reset_mid");
    @(negedge clk);
    reset = 1'b1;
    exp_dec = 1'b0;
    first_conversion("conv_after_reset");
    check_display("hex_after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
